// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared stall encoding, bus-width defaults and stall-vector bit positions
package if_id_queue_pkg;

    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

endpackage

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - instruction queue storage, wrapping pointers and occupancy count
module if_id_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clear,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [W-1:0]                   i_data,
    output logic [W-1:0]                   o_data,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Full/empty come from the count so equal pointers are never ambiguous.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_reset && !i_clear) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID queue with registered ID output; IF_ID_BYPASS_EN enables empty-queue bypass
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int DEPTH  = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [5:0]                     i_stall,
    input  logic                           i_flush,
    input  logic                           i_valid,
    input  logic [ADDR_W-1:0]              i_pc,
    input  logic [INST_W-1:0]              i_inst,
    output logic                           o_ready,
    output logic [ADDR_W-1:0]              o_pc,
    output logic [INST_W-1:0]              o_inst,
    output logic                           o_valid,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int W = ADDR_W + INST_W;

    logic              w_full;
    logic              w_empty;
    logic [W-1:0]      w_head;
    logic              w_id_go;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_bypass;
    logic              w_unused_stall;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;

    assign w_unused_stall = ^{i_stall[5:3], i_stall[0]};

    assign o_ready  = !w_full;
    assign w_id_go  = !i_flush && (i_stall[STALL_ID] == NOT_STOP);
    assign w_accept = i_valid && !w_full && (i_stall[STALL_IF] == NOT_STOP) && !i_flush;
    assign w_pop    = w_id_go && !w_empty;

`ifdef IF_ID_BYPASS_EN
    assign w_bypass = w_id_go && w_empty && w_accept;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_accept && !w_bypass;

    if_id_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({i_pc, i_inst}),
        .o_data  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ID stall holds the register; otherwise load the head, the bypassed word, or a bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_pc    <= '0;
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else if (i_stall[STALL_ID] == NOT_STOP) begin
            if (!w_empty) begin
                {r_pc, r_inst} <= w_head;
                r_valid        <= 1'b1;
            end else if (w_bypass) begin
                r_pc    <= i_pc;
                r_inst  <= i_inst;
                r_valid <= 1'b1;
            end else begin
                r_pc    <= '0;
                r_inst  <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue with randomized fetch/stall/flush traffic
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [5:0]  i_stall = '0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_inst = '0;
    logic        o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_valid;
    logic [2:0]  o_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    int          mcnt = 0;
    logic        mvalid = 1'b0;
    logic        adv = 1'b0;
    logic [31:0] pc_ctr = 32'h100;

    always #5 clk = ~clk;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_stall (i_stall),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .i_pc    (i_pc),
        .i_inst  (i_inst),
        .o_ready (o_ready),
        .o_pc    (o_pc),
        .o_inst  (o_inst),
        .o_valid (o_valid),
        .o_count (o_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check state at negedge, drive inputs, then advance the queue model at posedge.
    task automatic cyc(input logic v, input logic s1, input logic s2, input logic fl, input logic rs);
        logic        acc;
        logic        byp;
        logic [63:0] w;
        @(negedge clk);
        chk("count", 64'(o_count), 64'(mcnt));
        chk("ready", 64'(o_ready), 64'(mcnt < DEPTH));
        chk("valid", 64'(o_valid), 64'(mvalid));
        if (!mvalid) chk("bubble_zero", {o_pc, o_inst}, 64'h0);
        w = {pc_ctr, 32'($urandom())};
        i_valid = v;
        i_pc    = w[63:32];
        i_inst  = w[31:0];
        i_stall = {3'b000, s2, s1, 1'b0};
        i_flush = fl;
        i_reset = rs;
        @(posedge clk);
        adv = !rs && !fl && !s2;
        if (rs || fl) begin
            exp_q.delete();
            mcnt   = 0;
            mvalid = 1'b0;
        end else begin
            acc = v && (mcnt < DEPTH) && !s1;
            byp = 1'b0;
            if (!s2) begin
                if (mcnt > 0) begin
                    mcnt--;
                    mvalid = 1'b1;
                end else begin
`ifdef IF_ID_BYPASS_EN
                    byp = acc;
`endif
                    mvalid = byp;
                end
            end
            if (acc) begin
                if (!byp) mcnt++;
                exp_q.push_back(w);
                pc_ctr += 32'd4;
            end
        end
    endtask

    initial begin : monitor
        logic [63:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (adv && o_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h expected none", {o_pc, o_inst});
                end else begin
                    w = exp_q.pop_front();
                    chk("out_word", {o_pc, o_inst}, w);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        pc_ctr = 32'h100;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        pc_ctr = 32'h100;
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        pc_ctr = 32'h200;
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        pc_ctr = 32'h300;
        for (int i = 0; i < 40; i++) cyc(1, 0, 1'((i / 3) % 2), 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
                ($urandom % 40) == 0, ($urandom % 150) == 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
